// File: rtl/checkers_turn_ctrl.sv
// Turn sequencer and move arbiter for an 8x8 checkers board.
// RED and BLACK take strict alternating turns. Each granted move is checked
// against the board. A legal move is written to the board, and a result code
// is reported for every evaluated move. A registered read port lets display
// logic look at any cell.
// Optional build macro CHECKERS_CAPTURE_EN enables single jump captures,
// per-side piece counting and game_over. Without it, only single diagonal
// steps are legal and game_over stays low.
module checkers_turn_ctrl #(
  parameter int unsigned TURN_TIMEOUT = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             game_new_i,
  input  logic             red_req_i,
  input  logic [2:0]       red_src_r_i,
  input  logic [2:0]       red_src_c_i,
  input  logic [2:0]       red_dst_r_i,
  input  logic [2:0]       red_dst_c_i,
  output logic             red_ack_o,
  input  logic             black_req_i,
  input  logic [2:0]       black_src_r_i,
  input  logic [2:0]       black_src_c_i,
  input  logic [2:0]       black_dst_r_i,
  input  logic [2:0]       black_dst_c_i,
  output logic             black_ack_o,
  output logic             turn_o,
  output logic             result_valid_o,
  output logic             result_ok_o,
  output logic [1:0]       err_code_o,
  output logic             timeout_pulse_o,
  output logic [CNT_W-1:0] move_count_o,
  input  logic [2:0]       rd_r_i,
  input  logic [2:0]       rd_c_i,
  output logic [1:0]       rd_piece_o,
  output logic             game_over_o
);

  localparam int unsigned COORD_W = 3;
  localparam int unsigned IDX_W   = 2 * COORD_W;
  localparam int unsigned N_CELLS = 64;
  localparam int unsigned TO_W    = (TURN_TIMEOUT > 0) ? $clog2(TURN_TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0;

  localparam logic [1:0] PC_EMPTY = 2'd0;
  localparam logic [1:0] PC_RED   = 2'd1;
  localparam logic [1:0] PC_BLACK = 2'd2;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_SRC  = 2'd1;
  localparam logic [1:0] ERR_DST  = 2'd2;
  localparam logic [1:0] ERR_GEOM = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CHECK = 1'b1
  } state_e;

  // Starting position: dark squares of rows 0-2 hold RED, rows 5-7 hold BLACK.
  function automatic logic [1:0] init_cell(input logic [IDX_W-1:0] idx);
    logic [COORD_W-1:0] r;
    logic [COORD_W-1:0] c;
    r = idx[IDX_W-1:COORD_W];
    c = idx[COORD_W-1:0];
    init_cell = PC_EMPTY;
    if ((r[0] ^ c[0]) == 1'b1) begin
      if (r < 3'd3)      init_cell = PC_RED;
      else if (r > 3'd4) init_cell = PC_BLACK;
    end
  endfunction

  state_e             state_q, state_d;
  logic               turn_q, turn_d;
  logic               red_ack_q, red_ack_d;
  logic               black_ack_q, black_ack_d;
  logic               result_valid_q, result_valid_d;
  logic               result_ok_q, result_ok_d;
  logic [1:0]         err_q, err_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   move_cnt_q, move_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [COORD_W-1:0] src_r_q, src_r_d, src_c_q, src_c_d;
  logic [COORD_W-1:0] dst_r_q, dst_r_d, dst_c_q, dst_c_d;
  logic [1:0]         board_q [N_CELLS];
  logic [1:0]         board_d [N_CELLS];
  logic [1:0]         rd_piece_q, rd_piece_d;

  logic               hold_req;
  logic               blocked;
  logic [1:0]         own;
  logic [IDX_W-1:0]   src_idx, dst_idx;
  logic signed [3:0]  dr, dc;
  logic               step_ok;
  logic               jump_ok;
  logic [1:0]         chk_err;

`ifdef CHECKERS_CAPTURE_EN
  localparam int unsigned PC_W    = 4;
  localparam logic [3:0]  PC_INIT = 4'd12;
  logic [PC_W-1:0]    red_pc_q, red_pc_d;
  logic [PC_W-1:0]    black_pc_q, black_pc_d;
  logic               game_over_q, game_over_d;
  logic [1:0]         opp;
  logic [COORD_W-1:0] mid_r, mid_c;
  logic [IDX_W-1:0]   mid_idx;
  assign blocked = game_over_q;
`else
  assign blocked = 1'b0;
`endif

  assign hold_req = turn_q ? black_req_i : red_req_i;

  // Move evaluation against the current board for the latched coordinates.
  always_comb begin
    own     = turn_q ? PC_BLACK : PC_RED;
    src_idx = {src_r_q, src_c_q};
    dst_idx = {dst_r_q, dst_c_q};
    dr      = $signed({1'b0, dst_r_q}) - $signed({1'b0, src_r_q});
    dc      = $signed({1'b0, dst_c_q}) - $signed({1'b0, src_c_q});
    step_ok = (dr == (turn_q ? -4'sd1 : 4'sd1)) && ((dc == 4'sd1) || (dc == -4'sd1));
    jump_ok = 1'b0;
`ifdef CHECKERS_CAPTURE_EN
    opp     = turn_q ? PC_RED : PC_BLACK;
    mid_r   = turn_q ? (src_r_q - 3'd1) : (src_r_q + 3'd1);
    mid_c   = (dc > 4'sd0) ? (src_c_q + 3'd1) : (src_c_q - 3'd1);
    mid_idx = {mid_r, mid_c};
    jump_ok = (dr == (turn_q ? -4'sd2 : 4'sd2)) &&
              ((dc == 4'sd2) || (dc == -4'sd2)) &&
              (board_q[mid_idx] == opp);
`endif
    chk_err = ERR_NONE;
    if (board_q[src_idx] != own)           chk_err = ERR_SRC;
    else if (board_q[dst_idx] != PC_EMPTY) chk_err = ERR_DST;
    else if (!(step_ok || jump_ok))        chk_err = ERR_GEOM;
  end

  // Next-state: grant, commit, timeout and re-initialisation.
  always_comb begin
    state_d        = state_q;
    turn_d         = turn_q;
    red_ack_d      = 1'b0;
    black_ack_d    = 1'b0;
    result_valid_d = 1'b0;
    result_ok_d    = result_ok_q;
    err_d          = err_q;
    timeout_d      = 1'b0;
    move_cnt_d     = move_cnt_q;
    to_cnt_d       = to_cnt_q;
    src_r_d        = src_r_q;
    src_c_d        = src_c_q;
    dst_r_d        = dst_r_q;
    dst_c_d        = dst_c_q;
    board_d        = board_q;
    rd_piece_d     = board_q[{rd_r_i, rd_c_i}];
`ifdef CHECKERS_CAPTURE_EN
    red_pc_d       = red_pc_q;
    black_pc_d     = black_pc_q;
`endif

    if (game_new_i) begin
      state_d     = ST_IDLE;
      turn_d      = 1'b0;
      result_ok_d = 1'b0;
      err_d       = ERR_NONE;
      move_cnt_d  = '0;
      to_cnt_d    = '0;
      rd_piece_d  = PC_EMPTY;
      for (int i = 0; i < N_CELLS; i++) board_d[i] = init_cell(IDX_W'(i));
`ifdef CHECKERS_CAPTURE_EN
      red_pc_d    = PC_INIT;
      black_pc_d  = PC_INIT;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!blocked) begin
            if (hold_req) begin
              src_r_d  = turn_q ? black_src_r_i : red_src_r_i;
              src_c_d  = turn_q ? black_src_c_i : red_src_c_i;
              dst_r_d  = turn_q ? black_dst_r_i : red_dst_r_i;
              dst_c_d  = turn_q ? black_dst_c_i : red_dst_c_i;
              red_ack_d   = ~turn_q;
              black_ack_d = turn_q;
              to_cnt_d = '0;
              state_d  = ST_CHECK;
            end else if (TURN_TIMEOUT != 0) begin
              if (to_cnt_q == TO_W'(TO_LAST)) begin
                timeout_d = 1'b1;
                turn_d    = ~turn_q;
                to_cnt_d  = '0;
              end else begin
                to_cnt_d  = to_cnt_q + TO_W'(1);
              end
            end
          end
        end
        ST_CHECK: begin
          result_valid_d = 1'b1;
          state_d        = ST_IDLE;
          if (chk_err == ERR_NONE) begin
            result_ok_d      = 1'b1;
            err_d            = ERR_NONE;
            board_d[dst_idx] = own;
            board_d[src_idx] = PC_EMPTY;
            turn_d           = ~turn_q;
            if (move_cnt_q != {CNT_W{1'b1}}) move_cnt_d = move_cnt_q + CNT_W'(1);
`ifdef CHECKERS_CAPTURE_EN
            if (jump_ok) begin
              board_d[mid_idx] = PC_EMPTY;
              if (turn_q) red_pc_d   = red_pc_q - PC_W'(1);
              else        black_pc_d = black_pc_q - PC_W'(1);
            end
`endif
          end else begin
            result_ok_d = 1'b0;
            err_d       = chk_err;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

`ifdef CHECKERS_CAPTURE_EN
    game_over_d = (red_pc_d == '0) || (black_pc_d == '0);
`endif
  end

  // State and output registers; reset loads the starting position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      turn_q         <= 1'b0;
      red_ack_q      <= 1'b0;
      black_ack_q    <= 1'b0;
      result_valid_q <= 1'b0;
      result_ok_q    <= 1'b0;
      err_q          <= ERR_NONE;
      timeout_q      <= 1'b0;
      move_cnt_q     <= '0;
      to_cnt_q       <= '0;
      src_r_q        <= '0;
      src_c_q        <= '0;
      dst_r_q        <= '0;
      dst_c_q        <= '0;
      rd_piece_q     <= PC_EMPTY;
      for (int i = 0; i < N_CELLS; i++) board_q[i] <= init_cell(IDX_W'(i));
    end else begin
      state_q        <= state_d;
      turn_q         <= turn_d;
      red_ack_q      <= red_ack_d;
      black_ack_q    <= black_ack_d;
      result_valid_q <= result_valid_d;
      result_ok_q    <= result_ok_d;
      err_q          <= err_d;
      timeout_q      <= timeout_d;
      move_cnt_q     <= move_cnt_d;
      to_cnt_q       <= to_cnt_d;
      src_r_q        <= src_r_d;
      src_c_q        <= src_c_d;
      dst_r_q        <= dst_r_d;
      dst_c_q        <= dst_c_d;
      rd_piece_q     <= rd_piece_d;
      board_q        <= board_d;
    end
  end

`ifdef CHECKERS_CAPTURE_EN
  // Piece counters and the derived game_over flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red_pc_q    <= PC_INIT;
      black_pc_q  <= PC_INIT;
      game_over_q <= 1'b0;
    end else begin
      red_pc_q    <= red_pc_d;
      black_pc_q  <= black_pc_d;
      game_over_q <= game_over_d;
    end
  end
`endif

  assign red_ack_o       = red_ack_q;
  assign black_ack_o     = black_ack_q;
  assign turn_o          = turn_q;
  assign result_valid_o  = result_valid_q;
  assign result_ok_o     = result_ok_q;
  assign err_code_o      = err_q;
  assign timeout_pulse_o = timeout_q;
  assign move_count_o    = move_cnt_q;
  assign rd_piece_o      = rd_piece_q;
  assign game_over_o     = blocked;

endmodule

// File: tb/tb_checkers_turn_ctrl.sv
// Self-checking bench for checkers_turn_ctrl: a vector table, hand sequences
// for the multi-cycle cases, and random moves checked against a board model.
module tb_checkers_turn_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, game_new;
  logic        red_req, black_req, red_ack, black_ack;
  logic [2:0]  red_src_r, red_src_c, red_dst_r, red_dst_c;
  logic [2:0]  black_src_r, black_src_c, black_dst_r, black_dst_c;
  logic        turn, result_valid, result_ok, timeout_pulse, game_over;
  logic [1:0]  err_code, rd_piece;
  logic [15:0] move_count;
  logic [2:0]  rd_r, rd_c;

  // Second instance with the timeout enabled and no requesters.
  logic        z1 = 1'b0;
  logic [2:0]  z3 = 3'd0;
  logic        t_red_ack, t_black_ack, t_turn, t_rv, t_ok, t_timeout, t_go;
  logic [1:0]  t_err, t_piece;
  logic [15:0] t_count;

  checkers_turn_ctrl #(.TURN_TIMEOUT(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .game_new_i(game_new),
    .red_req_i(red_req), .red_src_r_i(red_src_r), .red_src_c_i(red_src_c),
    .red_dst_r_i(red_dst_r), .red_dst_c_i(red_dst_c), .red_ack_o(red_ack),
    .black_req_i(black_req), .black_src_r_i(black_src_r), .black_src_c_i(black_src_c),
    .black_dst_r_i(black_dst_r), .black_dst_c_i(black_dst_c), .black_ack_o(black_ack),
    .turn_o(turn), .result_valid_o(result_valid), .result_ok_o(result_ok),
    .err_code_o(err_code), .timeout_pulse_o(timeout_pulse), .move_count_o(move_count),
    .rd_r_i(rd_r), .rd_c_i(rd_c), .rd_piece_o(rd_piece), .game_over_o(game_over)
  );

  checkers_turn_ctrl #(.TURN_TIMEOUT(8), .CNT_W(16)) dut_to (
    .clk(clk), .rst(rst), .game_new_i(z1),
    .red_req_i(z1), .red_src_r_i(z3), .red_src_c_i(z3),
    .red_dst_r_i(z3), .red_dst_c_i(z3), .red_ack_o(t_red_ack),
    .black_req_i(z1), .black_src_r_i(z3), .black_src_c_i(z3),
    .black_dst_r_i(z3), .black_dst_c_i(z3), .black_ack_o(t_black_ack),
    .turn_o(t_turn), .result_valid_o(t_rv), .result_ok_o(t_ok),
    .err_code_o(t_err), .timeout_pulse_o(t_timeout), .move_count_o(t_count),
    .rd_r_i(z3), .rd_c_i(z3), .rd_piece_o(t_piece), .game_over_o(t_go)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int mb [8][8];
  int mturn, mcount, mred, mblk;

  function automatic void model_init();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mb[r][c] = ((r + c) % 2 == 1) ? ((r < 3) ? 1 : ((r > 4) ? 2 : 0)) : 0;
    mturn = 0; mcount = 0; mred = 12; mblk = 12;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int model_err(input int p, input int sr, input int sc, input int dr, input int dc);
    int own, opp, fwd, ddr, ddc;
    own = p ? 2 : 1; opp = p ? 1 : 2; fwd = p ? -1 : 1;
    ddr = dr - sr; ddc = dc - sc;
    if (mb[sr][sc] != own) return 1;
    if (mb[dr][dc] != 0) return 2;
    if (ddr == fwd && iabs(ddc) == 1) return 0;
`ifdef CHECKERS_CAPTURE_EN
    if (ddr == 2 * fwd && iabs(ddc) == 2 && mb[sr + fwd][sc + ddc / 2] == opp) return 0;
`else
    if (opp < 0) return 0;
`endif
    return 3;
  endfunction

  function automatic void model_apply(input int p, input int sr, input int sc, input int dr, input int dc);
    mb[dr][dc] = p ? 2 : 1;
    mb[sr][sc] = 0;
    if (iabs(dc - sc) == 2) begin
      mb[(sr + dr) / 2][(sc + dc) / 2] = 0;
      if (p) mred--; else mblk--;
    end
    mturn = 1 - mturn;
    mcount++;
  endfunction

  function automatic int model_go();
`ifdef CHECKERS_CAPTURE_EN
    return (mred == 0 || mblk == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int p, input logic v, input int sr, input int sc, input int dr, input int dc);
    if (p == 0) begin
      red_req = v; red_src_r = 3'(sr); red_src_c = 3'(sc); red_dst_r = 3'(dr); red_dst_c = 3'(dc);
    end else begin
      black_req = v; black_src_r = 3'(sr); black_src_c = 3'(sc); black_dst_r = 3'(dr); black_dst_c = 3'(dc);
    end
  endtask

  task automatic do_move(input int p, input int sr, input int sc, input int dr, input int dc,
                         output int ok, output int err);
    int exp_err, waited;
    logic got;
    ok = -1; err = -1;
    exp_err = model_err(p, sr, sc, dr, dc);
    set_req(p, 1'b1, sr, sc, dr, dc);
    if (model_go() != 0) begin
      repeat (4) begin
        @(posedge clk); #1;
        check("ack_while_game_over", p ? black_ack : red_ack, 0);
      end
      set_req(p, 1'b0, sr, sc, dr, dc);
      return;
    end
    waited = 0; got = 1'b0;
    while (!got && waited < 8) begin
      @(posedge clk); #1;
      waited++;
      got = p ? black_ack : red_ack;
    end
    set_req(p, 1'b0, sr, sc, dr, dc);
    check("ack_latency", waited, 1);
    if (!got) return;
    check("other_ack", p ? red_ack : black_ack, 0);
    check("early_result_valid", result_valid, 0);
    @(posedge clk); #1;
    check("result_valid", result_valid, 1);
    ok = int'(result_ok); err = int'(err_code);
    check("result_ok", result_ok, (exp_err == 0) ? 1 : 0);
    check("err_code", err_code, exp_err);
    if (exp_err == 0) model_apply(p, sr, sc, dr, dc);
    check("turn", turn, mturn);
    check("move_count", move_count, mcount);
    check("game_over", game_over, model_go());
  endtask

  task automatic read_check(input int r, input int c);
    rd_r = 3'(r); rd_c = 3'(c);
    @(posedge clk); #1;
    check("rd_piece", rd_piece, mb[r][c]);
  endtask

  typedef struct {
    int p, sr, sc, dr, dc;
    int exp_ok, exp_err, exp_turn;
  } vec_t;

  vec_t vt [9];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ok, err, p, sr, sc, dr, dc;
    int cand[$];

    vt[0] = '{0, 2, 1, 3, 2, 1, 0, 1};
    vt[1] = '{1, 5, 0, 4, 1, 1, 0, 0};
    vt[2] = '{0, 3, 2, 5, 4, 0, 2, 0};  // destination holds BLACK
    vt[3] = '{0, 3, 2, 4, 2, 0, 3, 0};  // straight step
    vt[4] = '{0, 3, 2, 2, 1, 0, 3, 0};  // backward step
    vt[5] = '{0, 2, 3, 3, 2, 0, 2, 0};
    vt[6] = '{0, 4, 1, 3, 0, 0, 1, 0};
    vt[7] = '{0, 2, 3, 3, 4, 1, 0, 1};
    vt[8] = '{1, 4, 1, 3, 0, 1, 0, 0};

    rst = 1'b1; game_new = 1'b0; rd_r = 3'd0; rd_c = 3'd0;
    set_req(0, 1'b0, 0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0, 0);
    model_init();
    repeat (3) @(posedge clk);
    #1;
    check("rst_turn", turn, 0);
    check("rst_move_count", move_count, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_ok", result_ok, 0);
    check("rst_err_code", err_code, 0);
    check("rst_rd_piece", rd_piece, 0);
    check("rst_ack", {red_ack, black_ack}, 0);
    check("rst_game_over", game_over, 0);
    rst = 1'b0;

    // Timeout instance counts idle cycles from reset release.
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k < 8) check("to_early", t_timeout, 0);
    end
    check("to_pulse", t_timeout, 1);
    check("to_turn", t_turn, 1);
    @(posedge clk); #1;
    check("to_width", t_timeout, 0);
    repeat (7) @(posedge clk);
    #1;
    check("to_second_pulse", t_timeout, 1);
    check("to_second_turn", t_turn, 0);
    check("no_timeout_when_disabled", {timeout_pulse, turn}, 0);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      do_move(vt[i].p, vt[i].sr, vt[i].sc, vt[i].dr, vt[i].dc, ok, err);
      check("tbl_ok", ok, vt[i].exp_ok);
      check("tbl_err", err, vt[i].exp_err);
      check("tbl_turn", turn, vt[i].exp_turn);
      read_check(vt[i].dr, vt[i].dc);
      read_check(vt[i].sr, vt[i].sc);
    end
    check("tbl_move_count", move_count, 4);

    // Non-turn BLACK request stays pending until RED commits.
    set_req(0, 1'b1, 3, 4, 4, 5);
    set_req(1, 1'b1, 5, 6, 4, 7);
    @(posedge clk); #1;
    check("pend_red_ack", red_ack, 1);
    check("pend_black_ack_early", black_ack, 0);
    set_req(0, 1'b0, 3, 4, 4, 5);
    @(posedge clk); #1;
    check("pend_red_valid", result_valid, 1);
    check("pend_red_ok", result_ok, 1);
    check("pend_turn_black", turn, 1);
    check("pend_black_ack_still_low", black_ack, 0);
    model_apply(0, 3, 4, 4, 5);
    @(posedge clk); #1;
    check("pend_black_ack", black_ack, 1);
    check("pend_ok_held", result_ok, 1);
    check("pend_valid_low", result_valid, 0);
    set_req(1, 1'b0, 5, 6, 4, 7);
    @(posedge clk); #1;
    check("pend_black_valid", result_valid, 1);
    check("pend_black_ok", result_ok, 1);
    model_apply(1, 5, 6, 4, 7);
    check("pend_turn_red", turn, mturn);
    check("pend_move_count", move_count, mcount);
    read_check(4, 7);

    // game_new in CHECK aborts the move.
    set_req(0, 1'b1, 3, 2, 4, 3);
    @(posedge clk); #1;
    check("abort_ack", red_ack, 1);
    set_req(0, 1'b0, 3, 2, 4, 3);
    game_new = 1'b1;
    @(posedge clk); #1;
    game_new = 1'b0;
    model_init();
    check("abort_no_valid", result_valid, 0);
    check("abort_turn", turn, 0);
    check("abort_move_count", move_count, 0);
    check("abort_result", {result_ok, err_code}, 0);
    check("abort_ack_low", {red_ack, black_ack}, 0);
    read_check(3, 2);
    read_check(4, 3);
    read_check(2, 1);
    read_check(5, 0);
    read_check(4, 7);

    // Random moves against the model.
    for (int n = 0; n < 200; n++) begin
      p = mturn;
      cand.delete();
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          if (mb[r][c] == (p ? 2 : 1)) cand.push_back(r * 8 + c);
      if (cand.size() > 0 && ($urandom % 4) != 0) begin
        sr = cand[$urandom_range(0, cand.size() - 1)];
        sc = sr % 8; sr = sr / 8;
      end else begin
        sr = $urandom_range(0, 7); sc = $urandom_range(0, 7);
      end
      dr = (sr + int'($urandom_range(0, 4)) - 2) & 7;
      dc = $urandom_range(0, 3);
      dc = (sc + ((dc < 2) ? dc - 2 : dc - 1)) & 7;
      do_move(p, sr, sc, dr, dc, ok, err);
      if (($urandom % 3) == 0) read_check($urandom_range(0, 7), $urandom_range(0, 7));
    end
    read_check(0, 1);
    read_check(7, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
